// File: rtl/smp_sched.sv
// Audio sample scheduler: period divider, per-voice capture with timeout, serial stereo mix.
// Define SMP_SCHED_SAT_EN to clamp the mix to 18-bit range instead of wrapping.
module smp_sched #(
   parameter int SAMPLE_CLKS  = 2083,
   parameter int VOICES_N     = 4,
   parameter int TIMEOUT_CLKS = 1024
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      run,
   output logic                      smp_trig,
   input  logic [VOICES_N-1:0]       voice_rdy,
   input  logic [18*VOICES_N-1:0]    voice_smp_l,
   input  logic [18*VOICES_N-1:0]    voice_smp_r,
   output logic                      mix_out_rdy,
   output logic signed [17:0]        mix_out_l,
   output logic signed [17:0]        mix_out_r,
   output logic                      smp_late,
   output logic                      smp_overrun
);
   localparam int CW = (SAMPLE_CLKS > 1) ? $clog2(SAMPLE_CLKS) : 1;
   localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, SUM, OUT} state_t;

   state_t               state, state_nx;
   logic [CW-1:0]        div_cnt;
   logic                 tick;
   logic [TW-1:0]        to_cnt;
   logic [2:0]           idx;
   logic [VOICES_N-1:0]  mask, cap_en;
   logic signed [17:0]   cap_l [VOICES_N];
   logic signed [17:0]   cap_r [VOICES_N];
   logic signed [20:0]   acc_l, acc_r;
   logic signed [17:0]   sel_l, sel_r, red_l, red_r;
   logic                 start, trig_nx, late_nx, ovr_nx, rdy_nx;

   assign tick = run && (div_cnt == CW'(SAMPLE_CLKS - 1));

   always_comb begin
      state_nx = state;
      start    = 1'b0;
      trig_nx  = 1'b0;
      late_nx  = 1'b0;
      rdy_nx   = 1'b0;
      cap_en   = '0;
      ovr_nx   = tick && (state != IDLE);
      case (state)
         IDLE: if (tick) begin
            start    = 1'b1;
            trig_nx  = 1'b1;
            state_nx = WAIT;
         end
         WAIT: begin
            // capture in the exit cycle too, so a full mask closes without a late flag
            cap_en = voice_rdy & ~mask;
            if (&(mask | cap_en)) begin
               state_nx = SUM;
            end else if (to_cnt == TW'(TIMEOUT_CLKS - 1)) begin
               state_nx = SUM;
               late_nx  = 1'b1;
            end
         end
         SUM: if (idx == 3'(VOICES_N - 1)) state_nx = OUT;
         OUT: begin
            rdy_nx   = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      sel_l = '0;
      sel_r = '0;
      for (int unsigned i = 0; i < VOICES_N; i++) begin
         if (idx == 3'(i) && mask[i]) begin
            sel_l = cap_l[i];
            sel_r = cap_r[i];
         end
      end
   end

`ifdef SMP_SCHED_SAT_EN
   always_comb begin
      if (acc_l > 21'sd131071)       red_l = 18'sh1FFFF;
      else if (acc_l < -21'sd131072) red_l = 18'sh20000;
      else                           red_l = acc_l[17:0];
      if (acc_r > 21'sd131071)       red_r = 18'sh1FFFF;
      else if (acc_r < -21'sd131072) red_r = 18'sh20000;
      else                           red_r = acc_r[17:0];
   end
`else
   assign red_l = acc_l[17:0];
   assign red_r = acc_r[17:0];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         div_cnt     <= '0;
         to_cnt      <= '0;
         idx         <= '0;
         mask        <= '0;
         acc_l       <= '0;
         acc_r       <= '0;
         smp_trig    <= 1'b0;
         mix_out_rdy <= 1'b0;
         smp_late    <= 1'b0;
         smp_overrun <= 1'b0;
         mix_out_l   <= '0;
         mix_out_r   <= '0;
         for (int unsigned i = 0; i < VOICES_N; i++) begin
            cap_l[i] <= '0;
            cap_r[i] <= '0;
         end
      end else begin
         state       <= state_nx;
         smp_trig    <= trig_nx;
         mix_out_rdy <= rdy_nx;
         smp_late    <= late_nx;
         smp_overrun <= ovr_nx;

         if (!run || tick) div_cnt <= '0;
         else              div_cnt <= div_cnt + CW'(1);

         if (start) begin
            mask   <= '0;
            to_cnt <= '0;
            idx    <= '0;
            acc_l  <= '0;
            acc_r  <= '0;
         end

         if (state == WAIT) begin
            mask   <= mask | cap_en;
            to_cnt <= to_cnt + TW'(1);
            for (int unsigned i = 0; i < VOICES_N; i++) begin
               if (cap_en[i]) begin
                  cap_l[i] <= voice_smp_l[18*i +: 18];
                  cap_r[i] <= voice_smp_r[18*i +: 18];
               end
            end
         end

         if (state == SUM) begin
            acc_l <= acc_l + {{3{sel_l[17]}}, sel_l};
            acc_r <= acc_r + {{3{sel_r[17]}}, sel_r};
            idx   <= idx + 3'd1;
         end

         if (state == OUT) begin
            mix_out_l <= red_l;
            mix_out_r <= red_r;
         end
      end
   end
endmodule

// File: doc/smp_sched.md
SMP_SCHED -- requirements
Module: smp_sched

Interface
REQ-001 Parameter SAMPLE_CLKS, default 2083: clocks per audio sample period.
REQ-002 Parameter VOICES_N, default 4: number of voice generators scheduled, range 1..8.
REQ-003 Parameter TIMEOUT_CLKS, default 1024: maximum clocks spent waiting for voices per frame.
REQ-004 Port clk, input, 1: sole clock; all logic rising-edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port run, input, 1: enables sample-period generation.
REQ-007 Port smp_trig, output, 1: one-cycle trigger broadcast to all voices.
REQ-008 Port voice_rdy, input, VOICES_N: per-voice sample-ready pulse.
REQ-009 Port voice_smp_l, input, 18*VOICES_N: packed signed left samples; voice i occupies bits [18*i+17:18*i].
REQ-010 Port voice_smp_r, input, 18*VOICES_N: packed signed right samples, same packing as left.
REQ-011 Port mix_out_rdy, output, 1: one-cycle pulse marking a valid mixed sample (feeds sddac sample_in_rdy).
REQ-012 Port mix_out_l, output, 18 signed: mixed left sample.
REQ-013 Port mix_out_r, output, 18 signed: mixed right sample.
REQ-014 Port smp_late, output, 1: one-cycle pulse when a frame closes by timeout.
REQ-015 Port smp_overrun, output, 1: one-cycle pulse when a period tick is dropped.

Function
REQ-016 Divider counts 0..SAMPLE_CLKS-1 and wraps while run=1; tick occurs in the cycle the count equals SAMPLE_CLKS-1; run=0 holds the count at 0 and produces no tick.
REQ-017 FSM states: IDLE, WAIT, SUM, OUT.
REQ-018 IDLE with tick: smp_trig=1 next cycle; clear capture mask, timeout counter and accumulators; go to WAIT.
REQ-019 WAIT: voice_rdy[i] with mask[i]=0 latches both samples of voice i and sets mask[i]; a repeat pulse from the same voice in the same frame is ignored (first capture wins).
REQ-020 WAIT exit: mask all ones -> SUM; else timeout counter reaching TIMEOUT_CLKS -> SUM with smp_late pulse; uncaptured voices contribute 0.
REQ-021 voice_rdy sampled in the same cycle as the timeout exit is captured.
REQ-022 SUM: add one voice per cycle, index 0..VOICES_N-1, into 21-bit signed left/right accumulators; lasts exactly VOICES_N cycles.
REQ-023 OUT: register the reduced accumulators (REQ-031) onto mix_out_l/r; pulse mix_out_rdy for one cycle; return to IDLE.
REQ-024 Latency: last capture in cycle c -> mix_out_rdy in cycle c+VOICES_N+2.
REQ-025 mix_out_l/r hold their value until the next OUT.
REQ-026 Tick while FSM is not in IDLE: tick is dropped with a smp_overrun pulse; divider phase is unaffected.
REQ-027 run deasserted mid-frame: the current frame completes normally.
REQ-028 voice_rdy outside WAIT is ignored.

Reset
REQ-029 On reset: FSM=IDLE; divider=0; mask=0; accumulators=0; smp_trig, mix_out_rdy, smp_late, smp_overrun=0; mix_out_l/r=0.
REQ-030 Reset asserted mid-frame: the frame is aborted with no mix_out_rdy; the first tick after release occurs SAMPLE_CLKS cycles after reset deasserts with run=1.

Configuration
REQ-031 Macro SMP_SCHED_SAT_EN:
- Defined: each accumulator is clamped to [-131072, 131071].
- Undefined: the low 18 bits are taken (two's-complement wrap).

Verification (VOICES_N=4, SAMPLE_CLKS=16, TIMEOUT_CLKS=8)
REQ-032 Voices return L=100,200,300,400 within 3 clocks of smp_trig -> mix_out_l=1000; mix_out_rdy exactly 6 cycles after the last voice_rdy; smp_trig period 16.
REQ-033 Voices 0-2 answer L=1000 each, voice 3 silent -> smp_late pulse after 8 WAIT cycles; mix_out_l=3000.
REQ-034 All four voices L=131071:
- SAT_EN defined -> mix_out_l=131071.
- SAT_EN undefined -> mix_out_l=-4 (wrap).
REQ-035 Voices stall for 20 clocks with TIMEOUT_CLKS raised to 64 -> exactly one smp_overrun pulse at the next tick; no second smp_trig in that frame.
REQ-036 Voice 1 pulses twice (L=5, then L=9) -> 5 used; run dropped mid-WAIT -> frame completes, then no further smp_trig.
REQ-037 Reset in SUM -> no mix_out_rdy; all outputs 0; next smp_trig 16 cycles after release.
